scan_dump_ctrl: RTL

Parametrised capture/dump sequencer for shadow scan chains. On a start request it optionally runs an error-injection window, pulses capture, then walks the enabled chains. For each chain it streams the shifted-out bits as framed bytes to the byte-wide UART transmitter. It generalises the fixed 8-chain controller to NCH chains, with a per-run channel mask, bit counts and a stall timeout.

---
 rtl/scan_dump_ctrl_if.sv | 32 +++
 rtl/scan_dump_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_dump_ctrl_if.sv
// Bundle of request, scan-chain and UART signals for the scan dump controller.
// The master modport is the driver side (run request, chains, UART status);
// the slave modport is the controller itself.
interface scan_dump_ctrl_if #(
  parameter int NCH   = 8,
  parameter int ERR_W = 3
);
  logic             start;
  logic             inj_err;
  logic [NCH-1:0]   chan_mask;
  logic [NCH-1:0]   ch_out;
  logic [NCH-1:0]   ch_out_vld;
  logic [NCH-1:0]   ch_out_done;
  logic             serial_busy;
  logic             err_en;
  logic [ERR_W-1:0] err_ctrl;
  logic             c_en;
  logic [NCH-1:0]   dump_en;
  logic             serial_en;
  logic [7:0]       serial_tx;
  logic             demo_done;

  modport master (
    output start, inj_err, chan_mask, ch_out, ch_out_vld, ch_out_done, serial_busy,
    input  err_en, err_ctrl, c_en, dump_en, serial_en, serial_tx, demo_done
  );

  modport slave (
    input  start, inj_err, chan_mask, ch_out, ch_out_vld, ch_out_done, serial_busy,
    output err_en, err_ctrl, c_en, dump_en, serial_en, serial_tx, demo_done
  );
endinterface

// File: rtl/scan_dump_ctrl.sv
// Capture/dump sequencer for shadow scan chains. A run optionally holds an
// error-injection window, pulses capture, then walks the masked chains and
// frames each chain's bits as bytes for a byte-wide UART:
//   header {A, ch}, data bytes (LSB-first, zero padded), {tflag, cnt[14:8]},
//   cnt[7:0]; the run ends with a 5A trailer byte.
// All outputs are registered; reset is asynchronous and abandons any frame.
module scan_dump_ctrl #(
  parameter int NCH        = 8,
  parameter int ERR_W      = 3,
  parameter int ERR_CYCLES = 4,
  parameter int TIMEOUT    = 1024
) (
  input logic            clk,
  input logic            rst,
  scan_dump_ctrl_if.slave bus
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int INJ_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INJ, S_CAP, S_HDR, S_DUMP, S_DBYTE, S_CNTH, S_CNTL, S_TRAIL, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_start_d;
  logic             r_inj;
  logic [NCH-1:0]   r_mask;
  logic [CH_W-1:0]  r_ch;
  logic [INJ_W-1:0] r_inj_cnt;
  logic [7:0]       r_shift;
  logic [3:0]       r_nbits;
  logic [14:0]      r_count;
  logic [TO_W-1:0]  r_idle;
  logic             r_tflag;
  logic             r_last;
  logic             r_guard;

  logic             r_err_en;
  logic [ERR_W-1:0] r_err_ctrl;
  logic             r_c_en;
  logic [NCH-1:0]   r_dump_en;
  logic             r_serial_en;
  logic [7:0]       r_serial_tx;
  logic             r_demo_done;

  logic             w_start_rise;
  logic             w_can_send;
  logic             w_send;
  logic [7:0]       w_tx_byte;
  logic             w_capture;
  logic             w_timeout;
  logic             w_bit;
  logic             w_done;
  logic             w_vld_act;
  logic [3:0]       w_ch4;
  logic [CH_W:0]    w_first;
  logic [CH_W:0]    w_next;
  logic [TO_W-1:0]  w_idle_inc;
  logic [NCH-1:0]   w_onehot;

  // Lowest set mask bit at index >= lo, returned as {found, index}.
  function automatic logic [CH_W:0] find_from(input logic [NCH-1:0] m, input int lo);
    logic [CH_W:0] res;
    res = {(CH_W + 1){1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        res = {1'b1, CH_W'(i)};
      end
    end
    return res;
  endfunction

  assign w_start_rise = bus.start & ~r_start_d;
  // The strobe cycle and the cycle after it are blind to serial_busy.
  assign w_can_send   = ~bus.serial_busy & ~r_serial_en & ~r_guard;
  assign w_bit        = bus.ch_out[r_ch];
  assign w_done       = bus.ch_out_done[r_ch];
  // Only bits presented while the shift enable is actually high count.
  assign w_vld_act    = bus.ch_out_vld[r_ch] & r_dump_en[r_ch];
  assign w_ch4        = 4'(r_ch);
  assign w_first      = find_from(r_mask, 0);
  assign w_next       = find_from(r_mask, int'(r_ch) + 1);
  assign w_idle_inc   = r_idle + TO_W'(1);
  assign w_onehot     = {{(NCH - 1){1'b0}}, 1'b1} << r_ch;

  // Next-state, byte-send decision and the byte to send.
  always_comb begin
    w_state_nxt = r_state;
    w_send      = 1'b0;
    w_tx_byte   = 8'h00;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          if (bus.inj_err) w_state_nxt = S_INJ;
          else             w_state_nxt = S_CAP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INJ: begin
        if (r_inj_cnt == INJ_W'(ERR_CYCLES - 1)) w_state_nxt = S_CAP;
        else                                      w_state_nxt = S_INJ;
      end
      S_CAP: begin
        if (w_first[CH_W]) w_state_nxt = S_HDR;
        else               w_state_nxt = S_TRAIL;
      end
      S_HDR: begin
        if (w_can_send) begin
          w_send      = 1'b1;
          w_tx_byte   = {4'hA, w_ch4};
          w_state_nxt = S_DUMP;
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_DUMP: begin
        if (w_vld_act) begin
          w_capture = 1'b1;
          if ((r_nbits == 4'd7) || w_done) w_state_nxt = S_DBYTE;
          else                             w_state_nxt = S_DUMP;
        end else if (w_idle_inc == TO_W'(TIMEOUT)) begin
          w_timeout = 1'b1;
          if (r_nbits != 4'd0) w_state_nxt = S_DBYTE;
          else                 w_state_nxt = S_CNTH;
        end else begin
          w_state_nxt = S_DUMP;
        end
      end
      S_DBYTE: begin
        if (w_can_send) begin
          w_send    = 1'b1;
          w_tx_byte = r_shift;
          if (r_last) w_state_nxt = S_CNTH;
          else        w_state_nxt = S_DUMP;
        end else begin
          w_state_nxt = S_DBYTE;
        end
      end
      S_CNTH: begin
        if (w_can_send) begin
          w_send      = 1'b1;
          w_tx_byte   = {r_tflag, r_count[14:8]};
          w_state_nxt = S_CNTL;
        end else begin
          w_state_nxt = S_CNTH;
        end
      end
      S_CNTL: begin
        if (w_can_send) begin
          w_send    = 1'b1;
          w_tx_byte = r_count[7:0];
          if (w_next[CH_W]) w_state_nxt = S_HDR;
          else              w_state_nxt = S_TRAIL;
        end else begin
          w_state_nxt = S_CNTL;
        end
      end
      S_TRAIL: begin
        if (w_can_send) begin
          w_send      = 1'b1;
          w_tx_byte   = 8'h5A;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_TRAIL;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, per-chain datapath and registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b1;  // a start held through reset is not an edge
      r_inj       <= 1'b0;
      r_mask      <= {NCH{1'b0}};
      r_ch        <= {CH_W{1'b0}};
      r_inj_cnt   <= {INJ_W{1'b0}};
      r_shift     <= 8'h00;
      r_nbits     <= 4'd0;
      r_count     <= 15'd0;
      r_idle      <= {TO_W{1'b0}};
      r_tflag     <= 1'b0;
      r_last      <= 1'b0;
      r_guard     <= 1'b0;
      r_err_en    <= 1'b0;
      r_err_ctrl  <= {ERR_W{1'b0}};
      r_c_en      <= 1'b0;
      r_dump_en   <= {NCH{1'b0}};
      r_serial_en <= 1'b0;
      r_serial_tx <= 8'h00;
      r_demo_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= bus.start;
      r_guard     <= r_serial_en;
      r_serial_en <= w_send;
      if (w_send) r_serial_tx <= w_tx_byte;
      case (r_state)
        S_IDLE: begin
          if (w_start_rise) begin
            r_inj       <= bus.inj_err;
            r_mask      <= bus.chan_mask;
            r_demo_done <= 1'b0;
            r_inj_cnt   <= {INJ_W{1'b0}};
          end
        end
        S_INJ: r_inj_cnt <= r_inj_cnt + INJ_W'(1);
        S_CAP: r_ch <= w_first[CH_W-1:0];
        S_HDR: begin
          r_shift <= 8'h00;
          r_nbits <= 4'd0;
          r_count <= 15'd0;
          r_idle  <= {TO_W{1'b0}};
          r_tflag <= 1'b0;
          r_last  <= 1'b0;
        end
        S_DUMP: begin
          if (w_capture) begin
            r_shift[r_nbits[2:0]] <= w_bit;
            r_nbits <= r_nbits + 4'd1;
            if (r_count != 15'h7FFF) r_count <= r_count + 15'd1;
            r_idle <= {TO_W{1'b0}};
            if (w_done) r_last <= 1'b1;
          end else if (w_timeout) begin
            r_tflag <= 1'b1;
            r_last  <= 1'b1;
          end else begin
            r_idle <= w_idle_inc;
          end
        end
        S_DBYTE: begin
          if (w_send) begin
            r_shift <= 8'h00;
            r_nbits <= 4'd0;
          end
        end
        S_CNTL: begin
          if (w_send && w_next[CH_W]) r_ch <= w_next[CH_W-1:0];
        end
        S_DONE: begin
          r_demo_done <= 1'b1;
          if (r_inj) r_err_ctrl <= r_err_ctrl + ERR_W'(1);
        end
        default: begin
          r_inj <= r_inj;
        end
      endcase
      r_err_en  <= (w_state_nxt == S_INJ);
      r_c_en    <= (w_state_nxt == S_CAP);
      r_dump_en <= (w_state_nxt == S_DUMP) ? w_onehot : {NCH{1'b0}};
    end
  end

  assign bus.err_en    = r_err_en;
  assign bus.err_ctrl  = r_err_ctrl;
  assign bus.c_en      = r_c_en;
  assign bus.dump_en   = r_dump_en;
  assign bus.serial_en = r_serial_en;
  assign bus.serial_tx = r_serial_tx;
  assign bus.demo_done = r_demo_done;

endmodule
